// File: rtl/common_types.sv
// common_types: shared types for the cpu_seq fetch/execute sequencer.
// Contents: state_t (exported on the LED debug port), opcode constants for
// the supported 6502 subset, and flags_t {N,Z,C}.
package common_types;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_OPLO  = 4'd1,
        S_OPHI  = 4'd2,
        S_READ  = 4'd3,
        S_WRITE = 4'd4,
        S_HALT  = 4'd5
    } state_t;

    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational datapath for cpu_seq.
// Ports:
//   a, b   in  DW  operands (a = accumulator, b = memory data)
//   cin    in  1   carry in
//   add    in  1   1 = {cout,y} = a+b+cin, 0 = pass b through (loads)
//   y      out DW  result
//   cout   out 1   carry out (equals cin when add=0, so C is preserved)
//   n, z   out 1   sign and zero of y
module cpu_alu #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic          add,
    output logic [DW-1:0] y,
    output logic          cout,
    output logic          n,
    output logic          z
);

    logic [DW:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        if (add) begin
            y    = sum[DW-1:0];
            cout = sum[DW];
        end else begin
            y    = b;
            cout = cin;
        end
        n = y[DW-1];
        z = (y == '0);
    end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: 6502-subset fetch/execute sequencer (NOP, LDA#, ADC#, LDA abs,
// STA abs, JMP abs). Owns PC, accumulator and flags and talks to memory over
// a req/ack port; any unknown opcode halts until reset.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   step                  (CPU_SINGLE_STEP_EN only) one instruction per pulse
//   mem_addr/req/we/wdata request side; held stable until mem_ack
//   mem_rdata, mem_ack    response side; rdata used in the ack cycle
//   pc, acc, flags        architectural state, flags = {N,Z,C}
//   state                 state_t code for the LED display
//   halted                1 after an illegal opcode
// Optional feature macro: CPU_SINGLE_STEP_EN
module cpu_seq
    import common_types::*;
#(
    parameter int               AW        = 16,
    parameter int               DW        = 8,
    parameter logic [AW-1:0]    RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst,
`ifdef CPU_SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [2:0]    flags,
    output logic [3:0]    state,
    output logic          halted
);

    state_t        st, st_n;
    logic [AW-1:0] pc_r, pc_n, ea, ea_n;
    logic [DW-1:0] acc_r, acc_n, lo, lo_n;
    logic [7:0]    ir, ir_n;
    flags_t        flg, flg_n;

    logic [AW-1:0]   pc_inc;
    logic [2*DW-1:0] ea_full;
    logic            fetch_go;
    logic            xfer;

    logic [DW-1:0] alu_y;
    logic          alu_cout, alu_n, alu_z, alu_add;

    assign pc_inc  = pc_r + {{(AW-1){1'b0}}, 1'b1};
    assign ea_full = {mem_rdata, lo};

`ifdef CPU_SINGLE_STEP_EN
    // The fetch is gated until a step pulse has been seen in S_FETCH; the
    // arm bit drops with the fetch ack so the next instruction waits again.
    logic armed;
    always_ff @(posedge clk) begin
        if (rst)
            armed <= 1'b0;
        else if (st == S_FETCH && !armed && step)
            armed <= 1'b1;
        else if (st == S_FETCH && armed && mem_ack)
            armed <= 1'b0;
    end
    assign fetch_go = armed;
`else
    assign fetch_go = 1'b1;
`endif

    // Request side decoded from registered state only: stable across stalls.
    always_comb begin
        mem_req   = !rst && (st != S_HALT) && (st != S_FETCH || fetch_go);
        mem_we    = !rst && (st == S_WRITE);
        mem_addr  = (st == S_READ || st == S_WRITE) ? ea : pc_r;
        mem_wdata = acc_r;
    end

    assign xfer    = mem_req && mem_ack;
    assign alu_add = (st == S_OPLO) && (ir == OP_ADC_IMM);

    cpu_alu #(.DW(DW)) u_alu (
        .a    (acc_r),
        .b    (mem_rdata),
        .cin  (flg.c),
        .add  (alu_add),
        .y    (alu_y),
        .cout (alu_cout),
        .n    (alu_n),
        .z    (alu_z)
    );

    always_comb begin
        st_n  = st;
        pc_n  = pc_r;
        acc_n = acc_r;
        flg_n = flg;
        ir_n  = ir;
        lo_n  = lo;
        ea_n  = ea;
        case (st)
            S_FETCH: if (xfer) begin
                ir_n = mem_rdata[7:0];
                pc_n = pc_inc;
                case (mem_rdata[7:0])
                    OP_NOP:                  st_n = S_FETCH;
                    OP_LDA_IMM, OP_ADC_IMM,
                    OP_LDA_ABS, OP_STA_ABS,
                    OP_JMP_ABS:              st_n = S_OPLO;
                    default:                 st_n = S_HALT;
                endcase
            end
            S_OPLO: if (xfer) begin
                pc_n = pc_inc;
                if (ir == OP_LDA_IMM || ir == OP_ADC_IMM) begin
                    acc_n = alu_y;
                    flg_n = '{n: alu_n, z: alu_z, c: alu_cout};
                    st_n  = S_FETCH;
                end else begin
                    lo_n = mem_rdata;
                    st_n = S_OPHI;
                end
            end
            S_OPHI: if (xfer) begin
                ea_n = ea_full[AW-1:0];
                if (ir == OP_JMP_ABS) begin
                    pc_n = ea_full[AW-1:0];
                    st_n = S_FETCH;
                end else begin
                    pc_n = pc_inc;
                    st_n = (ir == OP_LDA_ABS) ? S_READ : S_WRITE;
                end
            end
            S_READ: if (xfer) begin
                acc_n = alu_y;
                flg_n = '{n: alu_n, z: alu_z, c: flg.c};
                st_n  = S_FETCH;
            end
            S_WRITE: if (xfer) st_n = S_FETCH;
            S_HALT:  st_n = S_HALT;
            default: st_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_FETCH;
            pc_r  <= RESET_VEC;
            acc_r <= '0;
            flg   <= '0;
            ir    <= '0;
            lo    <= '0;
            ea    <= '0;
        end else begin
            st    <= st_n;
            pc_r  <= pc_n;
            acc_r <= acc_n;
            flg   <= flg_n;
            ir    <= ir_n;
            lo    <= lo_n;
            ea    <= ea_n;
        end
    end

    assign pc     = pc_r;
    assign acc    = acc_r;
    assign flags  = flg;
    assign state  = st;
    assign halted = (st == S_HALT);

endmodule
